// File: rtl/psdmult_sched_pkg.sv
// Shared state encoding and datapath widths for the psdmult scheduler.
package psdmult_sched_pkg;

    localparam int OPW = 16;
    localparam int PW  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/psdmult_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first pending request after ptr, wrapping.
// Purely combinational; grants nothing while en is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/psdmult_sched.sv
// Round-robin scheduler sharing one psdmult sequential multiplier.
// Optional perf counters under PSDMULT_SCHED_PERFCNT_EN.
module psdmult_sched
    import psdmult_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MULT_CYCLES = 16,
    parameter int IDW         = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [PW-1:0]     res_p,
    output logic              mult_start,
    output logic              mult_stop,
    output logic [OPW-1:0]    mult_a,
    output logic [OPW-1:0]    mult_b,
    input  logic [PW-1:0]     mult_p
`ifdef PSDMULT_SCHED_PERFCNT_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy
`endif
);

    localparam int CW = $clog2(MULT_CYCLES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [PW-1:0]   res_p_q, res_p_d;
    logic            mult_stop_q, mult_stop_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  sel;
    logic            idle;

    assign idle = (state_q == S_IDLE);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (idle),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Operands follow the live grant in IDLE, then stay on the owner.
    assign sel        = idle ? gnt_id : cur_id_q;
    assign mult_a     = req_a[int'(sel)*OPW +: OPW];
    assign mult_b     = req_b[int'(sel)*OPW +: OPW];
    assign req_ready  = gnt;
    assign mult_start = |gnt;
    assign mult_stop  = mult_stop_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;

    // Preg only becomes valid during DONE, so pass it through that cycle.
    assign res_p = (state_q == S_DONE) ? mult_p : res_p_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        cur_id_d    = cur_id_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_p_d     = res_p_q;
        mult_stop_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    cur_id_d = gnt_id;
                    ptr_d    = gnt_id;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(MULT_CYCLES - 1)) begin
                    state_d     = S_STOP;
                    mult_stop_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                state_d     = S_DONE;
                res_valid_d = 1'b1;
                res_id_d    = cur_id_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
                res_p_d = mult_p;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            cur_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_p_q     <= '0;
            mult_stop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            cur_id_q    <= cur_id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_p_q     <= res_p_d;
            mult_stop_q <= mult_stop_d;
        end
    end

`ifdef PSDMULT_SCHED_PERFCNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_ops_d  = perf_ops_q;
        perf_busy_d = perf_busy_q;
        if (state_q == S_DONE) perf_ops_d = perf_ops_q + 32'd1;
        if (!idle) perf_busy_d = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_psdmult_sched.sv
// Directed bench for psdmult_sched with a behavioural psdmult stand-in.
// Perf-counter checks are built when PSDMULT_SCHED_PERFCNT_EN is defined.
module tb_psdmult_sched;

    localparam int NREQ = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [63:0]     req_a;
    logic [63:0]     req_b;
    logic [3:0]      req_ready;
    logic            res_valid;
    logic [1:0]      res_id;
    logic [31:0]     res_p;
    logic            mult_start;
    logic            mult_stop;
    logic [15:0]     mult_a;
    logic [15:0]     mult_b;
    logic [31:0]     mult_p;
`ifdef PSDMULT_SCHED_PERFCNT_EN
    logic [31:0]     perf_ops;
    logic [31:0]     perf_busy;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    psdmult_sched #(
        .NREQ        (4),
        .MULT_CYCLES (16),
        .IDW         (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_p      (res_p),
        .mult_start (mult_start),
        .mult_stop  (mult_stop),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_p     (mult_p)
`ifdef PSDMULT_SCHED_PERFCNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_busy  (perf_busy)
`endif
    );

    // Multiplier stand-in: latch on start, load product on stop.
    logic signed [15:0] ma, mb;
    always @(posedge clock) begin
        if (reset) begin
            mult_p <= '0;
        end else begin
            if (mult_start) begin
                ma <= mult_a;
                mb <= mult_b;
            end
            if (mult_stop) mult_p <= ma * mb;
        end
    end

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t tv[6];
    vec_t rr[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [15:0] a,
                           input logic [15:0] b, input logic v);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_valid[id]      = v;
    endtask

    task automatic wait_grant(output int gcyc);
        logic seen = 1'b0;
        gcyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (|req_ready) begin
                seen = 1'b1;
                gcyc = cyc;
                break;
            end
        end
        if (!seen) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_res(output int rcyc);
        logic seen = 1'b0;
        rcyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (res_valid) begin
                seen = 1'b1;
                rcyc = cyc;
                break;
            end
        end
        if (!seen) chk("res_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        req_valid = '0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic drop_after_edge(input int id);
        @(posedge clock);
        #1 req_valid[id] = 1'b0;
    endtask

    int g, r, g0, nres;

    initial begin
        tv[0] = '{0, 16'd3,      -16'sd5,    32'hFFFF_FFF1};
        tv[1] = '{0, 16'h8000,   16'h8000,   32'h4000_0000};
        tv[2] = '{1, 16'h7FFF,   16'h8000,   32'hC000_8000};
        tv[3] = '{2, 16'd0,      16'hFFFF,   32'h0000_0000};
        tv[4] = '{3, 16'd100,    16'd200,    32'h0000_4E20};
        tv[5] = '{1, -16'sd7,    16'd9,      32'hFFFF_FFC1};
        rr[0] = '{0, 16'd2,      16'd3,      32'h0000_0006};
        rr[1] = '{1, -16'sd4,    16'd5,      32'hFFFF_FFEC};
        rr[2] = '{2, 16'd1000,   -16'sd1000, 32'hFFF0_BDC0};
        rr[3] = '{3, -16'sd300,  -16'sd300,  32'h0001_5F90};

        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready",     32'(req_ready),  32'd0);
        chk("rst_res_valid", 32'(res_valid),  32'd0);
        chk("rst_res_id",    32'(res_id),     32'd0);
        chk("rst_res_p",     res_p,           32'd0);
        chk("rst_start",     32'(mult_start), 32'd0);
        chk("rst_stop",      32'(mult_stop),  32'd0);

        // single requests, one at a time
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1 set_req(tv[i].id, tv[i].a, tv[i].b, 1'b1);
            wait_grant(g);
            chk("tv_ready", 32'(req_ready), 32'(1 << tv[i].id));
            chk("tv_mult_a", 32'(mult_a), 32'(tv[i].a));
            chk("tv_mult_b", 32'(mult_b), 32'(tv[i].b));
            drop_after_edge(tv[i].id);
            wait_res(r);
            chk("tv_latency", 32'(r - g), 32'd18);
            chk("tv_res_id", 32'(res_id), 32'(tv[i].id));
            chk("tv_res_p", res_p, tv[i].p);
            @(negedge clock);
            chk("tv_pulse", 32'(res_valid), 32'd0);
            chk("tv_hold_p", res_p, tv[i].p);
        end

        // all four at once: order 0,1,2,3 every 19 cycles
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, rr[i].a, rr[i].b, 1'b1);
        g0 = -1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            if (i == 0) g0 = g;
            chk("rr_ready", 32'(req_ready), 32'(1 << i));
            chk("rr_cycle", 32'(g - g0), 32'(19 * i));
            drop_after_edge(i);
            wait_res(r);
            chk("rr_res_id", 32'(res_id), 32'(i));
            chk("rr_res_p", res_p, rr[i].p);
        end

        // req1 held; req2 arrives mid-RUN and must go next
        do_reset();
        set_req(1, 16'd12, 16'd12, 1'b1);
        wait_grant(g);
        chk("fair_g1", 32'(req_ready), 32'd2);
        repeat (5) @(posedge clock);
        #1 set_req(2, 16'hFFFF, 16'd1, 1'b1);
        wait_res(r);
        chk("fair_r1_id", 32'(res_id), 32'd1);
        chk("fair_r1_p", res_p, 32'h0000_0090);
        wait_grant(g);
        chk("fair_g2", 32'(req_ready), 32'd4);
        drop_after_edge(2);
        wait_res(r);
        chk("fair_r2_id", 32'(res_id), 32'd2);
        chk("fair_r2_p", res_p, 32'hFFFF_FFFF);
        wait_grant(g);
        chk("fair_g1_again", 32'(req_ready), 32'd2);
        drop_after_edge(1);
        wait_res(r);
        chk("fair_r3_id", 32'(res_id), 32'd1);

        // reset in RUN cycle 7 discards the operation
        @(posedge clock);
        #1 set_req(0, 16'd5, 16'd5, 1'b1);
        wait_grant(g);
        drop_after_edge(0);
        repeat (6) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_valid", 32'(res_valid),  32'd0);
        chk("mid_rst_id",    32'(res_id),     32'd0);
        chk("mid_rst_p",     res_p,           32'd0);
        chk("mid_rst_stop",  32'(mult_stop),  32'd0);
        chk("mid_rst_start", 32'(mult_start), 32'd0);
        chk("mid_rst_ready", 32'(req_ready),  32'd0);
        nres = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (res_valid || mult_stop) nres++;
        end
        chk("mid_rst_quiet", 32'(nres), 32'd0);
        @(posedge clock);
        #1 set_req(0, 16'd7, 16'd6, 1'b1);
        wait_grant(g);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        drop_after_edge(0);
        wait_res(r);
        chk("post_rst_lat", 32'(r - g), 32'd18);
        chk("post_rst_p", res_p, 32'h0000_002A);

`ifdef PSDMULT_SCHED_PERFCNT_EN
        do_reset();
        @(negedge clock);
        chk("perf_ops_rst", perf_ops, 32'd0);
        chk("perf_busy_rst", perf_busy, 32'd0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) set_req(i, rr[i].a, rr[i].b, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_grant(g);
            drop_after_edge(i);
            wait_res(r);
        end
        @(negedge clock);
        chk("perf_ops", perf_ops, 32'd3);
        chk("perf_busy", perf_busy, 32'd54);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
